// File: rtl/nor_resp_checker.sv
// Response checker for a two-input NOR cell: compares the observed y against the
// golden NOR of each applied vector, counts vectors/mismatches and keeps the first failure.
module nor_resp_checker #(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             vld,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_vld,
    output logic             fail_a,
    output logic             fail_b,
    output logic             fail_y,
    output logic [CNT_W-1:0] fail_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // DRAIN must cover the full pipeline so the stop-cycle vector is still compared.
    localparam int               DRAIN_LEN  = (LAT < 1) ? 1 : LAT;
    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_q;
    logic [3:0]         drain_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [CNT_W-1:0]   vec_q;
    logic [CNT_W-1:0]   err_q;
    logic               fail_vld_q;
    logic               fail_a_q;
    logic               fail_b_q;
    logic               fail_y_q;
    logic [CNT_W-1:0]   fail_idx_q;

    logic [CNT_W-1:0]   vec_d;
    logic [CNT_W-1:0]   err_d;
    logic               fail_vld_d;
    logic               fail_a_d;
    logic               fail_b_d;
    logic               fail_y_d;
    logic [CNT_W-1:0]   fail_idx_d;

    logic               push_v_s;
    logic               tail_a_s;
    logic               tail_b_s;
    logic               tail_exp_s;
    logic               tail_v_s;
    logic               cmp_s;
    logic               mis_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    // Vectors enter the pipeline only while the session is running.
    always_comb begin
        push_v_s = vld & (state_q == ST_RUN);
    end

    generate
        if (LAT == 0) begin : g_lat0
            // Zero latency: compare the live vector against the live y.
            always_comb begin
                tail_a_s   = a;
                tail_b_s   = b;
                tail_exp_s = ~(a | b);
                tail_v_s   = push_v_s;
            end
        end else begin : g_pipe
            logic [3:0] pipe_q [LAT];

            // Shift pipeline of {a, b, expected y, valid}; reset drops pre-reset vectors.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        pipe_q[i] <= 4'b0000;
                    end
                end else begin
                    pipe_q[0] <= {a, b, ~(a | b), push_v_s};
                    for (int i = 1; i < LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            // Pipeline tail lines up with the y belonging to that vector.
            always_comb begin
                tail_a_s   = pipe_q[LAT-1][3];
                tail_b_s   = pipe_q[LAT-1][2];
                tail_exp_s = pipe_q[LAT-1][1];
                tail_v_s   = pipe_q[LAT-1][0];
            end
        end
    endgenerate

    // Compare, saturating counters and first-fail capture next-state.
    always_comb begin
        cmp_s      = tail_v_s & ((state_q == ST_RUN) | (state_q == ST_DRAIN));
        mis_s      = cmp_s & (y != tail_exp_s);
        vec_d      = sat_inc(vec_q, cmp_s);
        err_d      = sat_inc(err_q, mis_s);
        fail_vld_d = fail_vld_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_y_d   = fail_y_q;
        fail_idx_d = fail_idx_q;
        if (mis_s && !fail_vld_q) begin
            fail_vld_d = 1'b1;
            fail_a_d   = tail_a_s;
            fail_b_d   = tail_b_s;
            fail_y_d   = y;
            fail_idx_d = vec_q;
        end else begin
            fail_vld_d = fail_vld_q;
        end
    end

    // Session FSM with registered status outputs; result updates are idle outside RUN/DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            drain_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            vec_q      <= '0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_a_q   <= 1'b0;
            fail_b_q   <= 1'b0;
            fail_y_q   <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            vec_q      <= vec_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_y_q   <= fail_y_d;
            fail_idx_q <= fail_idx_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        vec_q      <= '0;
                        err_q      <= '0;
                        fail_vld_q <= 1'b0;
                        fail_a_q   <= 1'b0;
                        fail_b_q   <= 1'b0;
                        fail_y_q   <= 1'b0;
                        fail_idx_q <= '0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DRAIN_LAST;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 4'd0) begin
                        // Pass uses next-state counts: the last compare may land in this cycle.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0) && (vec_d != '0);
                    end else begin
                        drain_q <= drain_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign vec_cnt  = vec_q;
    assign err_cnt  = err_q;
    assign fail_vld = fail_vld_q;
    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_y   = fail_y_q;
    assign fail_idx = fail_idx_q;

endmodule
